// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp/phase types and helpers for the round-robin traffic controller
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } color_t;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  // Lamp shown by one direction: only the owner follows the phase, everyone else is red.
  function automatic color_t light_of(phase_t ph, bit is_active);
    color_t c;
    c = RED;
    if (is_active) begin
      case (ph)
        PH_GREEN:  c = GREEN;
        PH_YELLOW: c = YELLOW;
        default:   c = RED;
      endcase
    end
    return c;
  endfunction

  // Largest of the three phase lengths; sizes the phase counter.
  function automatic int max3(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/traffic_rr_ctrl_rr_arbiter.sv
// rtl/traffic_rr_ctrl_rr_arbiter.sv - combinational round-robin pick of the next green direction
module rr_arbiter
  import traffic_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  // Scan last+N down to last+1 so the candidate nearest after last overrides the rest;
  // with no request the current owner is kept.
  always_comb begin
    logic [IW-1:0] cand;
    grant_idx = last;
    any       = |req;
    cand      = '0;
    for (int j = N; j >= 1; j--) begin
      cand = IW'((int'(last) + j) % N);
      if (req[cand]) grant_idx = cand;
    end
  end

endmodule

// File: rtl/traffic_rr_ctrl.sv
// rtl/traffic_rr_ctrl.sv - N-direction traffic-light controller with round-robin green grants
module traffic_rr_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR     = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  localparam int DW       = $clog2(N_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DIR-1:0]   sense,
  output logic [2*N_DIR-1:0] light,
  output logic [DW-1:0]      active_dir,
  output logic [1:0]         phase
);

  localparam int CW = $clog2(max3(GREEN_MAX, YELLOW_T, ALLRED_T)) + 1;
  localparam logic [CW-1:0] CNT_SAT = '1;

  phase_t           phase_q, phase_d;
  logic [DW-1:0]    dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_DIR-1:0] req_q, req_d;

  logic [N_DIR-1:0] act_onehot;
  logic [N_DIR-1:0] pend;
  logic [DW-1:0]    grant_idx;
  logic             pend_any;
  logic             green_done;

  assign act_onehot = N_DIR'(1) << dir_q;
  // The owner's own sensor never counts as a competing request.
  assign pend       = req_q | (sense & ~act_onehot);

  rr_arbiter #(
    .N  (N_DIR),
    .IW (DW)
  ) u_arb (
    .req       (pend),
    .last      (dir_q),
    .grant_idx (grant_idx),
    .any       (pend_any)
  );

  // Green ends only once the minimum has elapsed and someone else waits; a busy owner keeps it up to the maximum.
  assign green_done = (int'(cnt_q) >= GREEN_MIN - 1) && pend_any &&
                      (!sense[dir_q] || (int'(cnt_q) >= GREEN_MAX - 1));

  // Next-state logic: phase sequencing, request latching and the phase-length counter.
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    req_d   = req_q | (sense & ~((phase_q == PH_GREEN) ? act_onehot : '0));
    case (phase_q)
      PH_GREEN: begin
        if (green_done) phase_d = PH_YELLOW;
      end
      PH_YELLOW: begin
        if (int'(cnt_q) == YELLOW_T - 1) phase_d = PH_ALLRED;
      end
      PH_ALLRED: begin
        if (int'(cnt_q) == ALLRED_T - 1) begin
          phase_d          = PH_GREEN;
          dir_d            = grant_idx;
          req_d[grant_idx] = 1'b0;
        end
      end
      default: phase_d = PH_GREEN;
    endcase
    if (phase_d != phase_q) cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else cnt_d = cnt_q + 1'b1;
  end

  // State registers; reset returns green to direction 0 and drops all latched requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      dir_q   <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Lamp decode straight from the phase and owner registers, so sense never reaches the lamps combinationally.
  always_comb begin
    light = '0;
    for (int i = 0; i < N_DIR; i++) begin
      light[2*i +: 2] = light_of(phase_q, dir_q == DW'(i));
    end
  end

  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule
